// File: rtl/pmem_arbiter.sv
// ============================================================================
// Module   : pmem_arbiter
// Brief    : Shares the single physical-memory port between the I-cache and
//            the D-cache. Grants one requester at a time, latches its command
//            and forwards the completion back to the owner. Ties alternate
//            round-robin so neither cache starves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_arbiter (
  input  logic         clk,
  input  logic         reset,

  // I-cache side
  input  logic         imem_read,
  input  logic [15:0]  imem_address,
  output logic [127:0] imem_rdata,
  output logic         imem_resp,

  // D-cache side
  input  logic         dmem_read,
  input  logic         dmem_write,
  input  logic [15:0]  dmem_address,
  input  logic [127:0] dmem_wdata,
  output logic [127:0] dmem_rdata,
  output logic         dmem_resp,

  // Physical memory side
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Requester identity encoding used by the grant and last-winner registers
  localparam logic c_GNT_I = 1'b0;
  localparam logic c_GNT_D = 1'b1;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_gnt;
  logic           r_last;
  logic           r_op_read;
  logic           r_op_write;
  logic [15:0]    r_addr;
  logic [127:0]   r_wdata;

  logic           w_i_req;
  logic           w_d_req;
  logic           w_load;
  logic           w_win;
  logic           w_busy;

  assign w_i_req = imem_read;
  assign w_d_req = dmem_read | dmem_write;
  assign w_busy  = (r_state == ST_BUSY);

  // Next-state and grant decision; a tie goes to whoever was not granted last
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_win       = c_GNT_I;
    case (r_state)
      ST_IDLE: begin
        if (w_i_req || w_d_req) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
          if (w_i_req && w_d_req) begin
            w_win = (r_last == c_GNT_I) ? c_GNT_D : c_GNT_I;
          end else begin
            w_win = w_d_req ? c_GNT_D : c_GNT_I;
          end
        end
      end
      ST_BUSY: begin
        if (pmem_resp) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and command latch; requester inputs are only
  // sampled on the grant edge so later changes cannot disturb the transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= c_GNT_I;
      r_last     <= c_GNT_I;
      r_op_read  <= 1'b0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_gnt  <= w_win;
        r_last <= w_win;
        if (w_win == c_GNT_D) begin
          // A writeback wins over a simultaneous read from the D-cache
          r_op_write <= dmem_write;
          r_op_read  <= ~dmem_write;
          r_addr     <= dmem_address;
          r_wdata    <= dmem_wdata;
        end else begin
          r_op_write <= 1'b0;
          r_op_read  <= 1'b1;
          r_addr     <= imem_address;
        end
      end
    end
  end

  // Strobes only while a transfer is owned; op_read/op_write are exclusive
  assign pmem_read    = w_busy & r_op_read;
  assign pmem_write   = w_busy & r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Read data is broadcast; only the completion pulse is steered by the grant
  assign imem_rdata = pmem_rdata;
  assign dmem_rdata = pmem_rdata;
  assign imem_resp  = w_busy & pmem_resp & ~reset & (r_gnt == c_GNT_I);
  assign dmem_resp  = w_busy & pmem_resp & ~reset & (r_gnt == c_GNT_D);

endmodule

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
// ============================================================================
// Module   : tb_pmem_arbiter
// Brief    : Self-checking bench for pmem_arbiter: a vector table, directed
//            corner-case sequences and randomized cache traffic checked against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_read;
  logic [15:0]  imem_address;
  logic [127:0] imem_rdata;
  logic         imem_resp;
  logic         dmem_read;
  logic         dmem_write;
  logic [15:0]  dmem_address;
  logic [127:0] dmem_wdata;
  logic [127:0] dmem_rdata;
  logic         dmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // Reference model: the transaction currently owning memory (if any), the
  // last winner and the command values last presented on the bus.
  bit           m_valid;
  bit           m_who_d;
  bit           m_wr;
  bit           m_last_d;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;

  // Outputs observed in the most recent tick
  bit           s_pr, s_pw, s_ir, s_dr;
  logic [15:0]  s_addr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_who_d  = 1'b0;
    m_wr     = 1'b0;
    m_last_d = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
  endtask

  task automatic set_in(input bit ir, input bit dr, input bit dw,
                        input logic [15:0] ia, input logic [15:0] da, input bit pr);
    imem_read    = ir;
    dmem_read    = dr;
    dmem_write   = dw;
    imem_address = ia;
    dmem_address = da;
    pmem_resp    = pr;
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge using the same input values the DUT sampled.
  task automatic tick();
    bit ir, dr, who;
    @(negedge clk);
    chk("pmem_read",    128'(pmem_read),    128'(m_valid && !m_wr));
    chk("pmem_write",   128'(pmem_write),   128'(m_valid && m_wr));
    chk("pmem_address", 128'(pmem_address), 128'(m_addr));
    chk("pmem_wdata",   pmem_wdata,         m_wdata);
    chk("imem_resp",    128'(imem_resp),    128'(m_valid && pmem_resp && !m_who_d && !reset));
    chk("dmem_resp",    128'(dmem_resp),    128'(m_valid && pmem_resp && m_who_d && !reset));
    chk("imem_rdata",   imem_rdata,         pmem_rdata);
    chk("dmem_rdata",   dmem_rdata,         pmem_rdata);
    s_pr   = pmem_read;
    s_pw   = pmem_write;
    s_ir   = imem_resp;
    s_dr   = dmem_resp;
    s_addr = pmem_address;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_valid) begin
      if (pmem_resp) m_valid = 1'b0;
    end else begin
      ir = imem_read;
      dr = dmem_read || dmem_write;
      if (ir || dr) begin
        who      = (ir && dr) ? !m_last_d : dr;
        m_valid  = 1'b1;
        m_who_d  = who;
        m_last_d = who;
        m_wr     = who && dmem_write;
        m_addr   = who ? dmem_address : imem_address;
        if (who) m_wdata = dmem_wdata;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          ir, dr, dw;
    logic [15:0] ia, da;
    bit          pr;
    bit          e_pr, e_pw;
    logic [15:0] e_addr;
    bit          e_ir, e_dr;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit ir, input bit dr, input bit dw, input logic [15:0] ia,
                     input logic [15:0] da, input bit pr, input bit e_pr, input bit e_pw,
                     input logic [15:0] e_addr, input bit e_ir, input bit e_dr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.pr = pr;
    v.e_pr = e_pr; v.e_pw = e_pw; v.e_addr = e_addr; v.e_ir = e_ir; v.e_dr = e_dr;
    tv.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          i_pend, d_pend, i_cool, d_cool;
    bit          prev_any;
    bit          order[$];
    logic [15:0] ra_i, ra_d;
    bit          rd_r, rd_w;

    // Power-up reset without checks (DUT state is unknown before the first edge)
    reset        = 1'b1;
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    dmem_wdata   = '0;
    pmem_rdata   = {4{32'hA5A5_0F0F}};
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // ---------------- vector table ----------------
    //   ir dr dw ia       da       pr   e_pr e_pw e_addr   e_ir e_dr
    add(1, 0, 0, 16'h1230, 16'h0000, 0,  0, 0, 16'h0000, 0, 0); // reset state, I request
    add(1, 0, 0, 16'h1230, 16'h0000, 0,  1, 0, 16'h1230, 0, 0);
    add(1, 0, 0, 16'h1230, 16'h0000, 0,  1, 0, 16'h1230, 0, 0);
    add(1, 0, 0, 16'h1230, 16'h0000, 0,  1, 0, 16'h1230, 0, 0);
    add(1, 0, 0, 16'h1230, 16'h0000, 1,  1, 0, 16'h1230, 1, 0); // resp on 4th strobe
    add(0, 0, 0, 16'h1230, 16'h0000, 1,  0, 0, 16'h1230, 0, 0); // resp in IDLE ignored
    add(0, 0, 1, 16'h0000, 16'h4560, 0,  0, 0, 16'h1230, 0, 0); // D write request
    add(0, 0, 1, 16'h0000, 16'h9999, 0,  0, 1, 16'h4560, 0, 0); // address change ignored
    add(0, 0, 1, 16'h0000, 16'h9999, 1,  0, 1, 16'h4560, 0, 1);
    add(0, 0, 0, 16'h0000, 16'h0000, 1,  0, 0, 16'h4560, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h7770, 0,  0, 0, 16'h4560, 0, 0); // read+write together
    add(0, 1, 1, 16'h0000, 16'h7770, 0,  0, 1, 16'h7770, 0, 0);
    add(0, 1, 1, 16'h0000, 16'h7770, 1,  0, 1, 16'h7770, 0, 1);
    add(0, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 16'h7770, 0, 0);
    add(1, 1, 0, 16'h1230, 16'h2220, 0,  0, 0, 16'h7770, 0, 0); // tie, last was D -> I
    add(1, 1, 0, 16'h1230, 16'h2220, 1,  1, 0, 16'h1230, 1, 0);
    add(0, 1, 0, 16'h1230, 16'h2220, 0,  0, 0, 16'h1230, 0, 0); // dead cycle, D sampled
    add(0, 1, 0, 16'h1230, 16'h2220, 1,  1, 0, 16'h2220, 0, 1);
    add(0, 0, 0, 16'h0000, 16'h0000, 0,  0, 0, 16'h2220, 0, 0);

    dmem_wdata = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    foreach (tv[k]) begin
      set_in(tv[k].ir, tv[k].dr, tv[k].dw, tv[k].ia, tv[k].da, tv[k].pr);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk($sformatf("tv%0d pmem_read", k),    128'(s_pr),   128'(tv[k].e_pr));
      chk($sformatf("tv%0d pmem_write", k),   128'(s_pw),   128'(tv[k].e_pw));
      chk($sformatf("tv%0d pmem_address", k), 128'(s_addr), 128'(tv[k].e_addr));
      chk($sformatf("tv%0d imem_resp", k),    128'(s_ir),   128'(tv[k].e_ir));
      chk($sformatf("tv%0d dmem_resp", k),    128'(s_dr),   128'(tv[k].e_dr));
    end

    // ---------------- both request right after reset: D first ----------------
    do_reset();
    dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    set_in(1, 0, 1, 16'h1111, 16'h2222, 0);
    tick();
    chk("both0 strobes idle", 128'({s_pr, s_pw}), 128'(2'b00));
    set_in(1, 0, 1, 16'h1111, 16'h2222, 1);
    tick();
    chk("both1 D write", 128'({s_pr, s_pw, s_dr, s_ir}), 128'(4'b0110));
    chk("both1 addr", 128'(s_addr), 128'(16'h2222));
    set_in(1, 0, 0, 16'h1111, 16'h2222, 0);
    tick();
    chk("both2 dead cycle", 128'({s_pr, s_pw}), 128'(2'b00));
    set_in(1, 0, 0, 16'h1111, 16'h2222, 1);
    tick();
    chk("both3 I read", 128'({s_pr, s_pw, s_dr, s_ir}), 128'(4'b1001));
    chk("both3 addr", 128'(s_addr), 128'(16'h1111));
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();

    // ---------------- continuous contention: D,I,D,I,D,I ----------------
    do_reset();
    prev_any = 1'b0;
    set_in(1, 1, 0, 16'hAAA0, 16'hBBB0, 1);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("resp pulse width", 128'((s_ir || s_dr) && prev_any), 128'(0));
      prev_any = s_ir || s_dr;
      if (s_ir) order.push_back(1'b0);
      if (s_dr) order.push_back(1'b1);
    end
    chk("rr count", 128'(order.size()), 128'(6));
    for (int k = 0; k < order.size() && k < 6; k++)
      chk($sformatf("rr grant%0d", k), 128'(order[k]), 128'((k % 2) == 0));
    set_in(0, 0, 0, 16'h0, 16'h0, 0);
    tick();

    // ---------------- reset during BUSY of an I read ----------------
    do_reset();
    set_in(1, 0, 0, 16'h3330, 16'h0, 0);
    tick();
    tick();
    chk("rb busy read", 128'(s_pr), 128'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_in(0, 0, 0, 16'h3330, 16'h0, 1);
    tick();
    chk("rb strobes after reset", 128'({s_pr, s_pw}), 128'(2'b00));
    chk("rb no resp", 128'({s_ir, s_dr}), 128'(2'b00));
    tick();
    chk("rb idle resp ignored", 128'({s_ir, s_dr}), 128'(2'b00));
    set_in(0, 0, 0, 16'h0, 16'h0, 0);

    // ---------------- randomized cache-like traffic ----------------
    do_reset();
    i_pend = 0; d_pend = 0; i_cool = 0; d_cool = 0;
    ra_i = 0; ra_d = 0; rd_r = 0; rd_w = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && !i_cool && ($urandom % 3 == 0)) begin
        i_pend = 1;
        ra_i   = 16'($urandom);
      end
      if (!d_pend && !d_cool && ($urandom % 3 == 0)) begin
        d_pend     = 1;
        ra_d       = 16'($urandom);
        rd_r       = 1'($urandom);
        rd_w       = 1'($urandom);
        if (!rd_r && !rd_w) rd_r = 1;
        dmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      i_cool = 0;
      d_cool = 0;
      reset  = ($urandom % 100 == 0);
      set_in(i_pend, d_pend && rd_r, d_pend && rd_w, ra_i, ra_d, ($urandom % 3 == 0));
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("rnd exclusive strobes", 128'(s_pr && s_pw), 128'(0));
      chk("rnd exclusive resp", 128'(s_ir && s_dr), 128'(0));
      if (s_ir) begin i_pend = 0; i_cool = 1; end
      if (s_dr) begin d_pend = 0; d_cool = 1; end
      if (reset) begin i_pend = 0; d_pend = 0; end
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
